// File: rtl/wb_commit_stage.sv
// rtl/wb_commit_stage.sv - MEM->WB pipeline register with valid/ready handshake, optional skid entry, flush and retire counter
// Main entry drives the outputs; the skid entry absorbs one bundle when WB stalls while MEM is still pushing.
module wb_commit_stage #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int N_CH   = 4,
   parameter int PC_W   = 32,
   parameter int SKID   = 1,
   parameter int CNT_W  = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N_CH-1:0]          in_we,
   input  logic [N_CH*ADDR_W-1:0]   in_addr,
   input  logic [N_CH*DATA_W-1:0]   in_data,
   input  logic [PC_W-1:0]          in_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [N_CH-1:0]          out_we,
   output logic [N_CH*ADDR_W-1:0]   out_addr,
   output logic [N_CH*DATA_W-1:0]   out_data,
   output logic [PC_W-1:0]          out_pc,
   output logic [1:0]               occupancy,
   output logic [CNT_W-1:0]         retire_cnt
);

   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_ONE   = 2'd1;
   localparam logic [1:0] S_TWO   = 2'd2;

   logic [1:0]               state_q, state_d;
   logic [N_CH-1:0]          main_we_q, main_we_d;
   logic [N_CH*ADDR_W-1:0]   main_addr_q, main_addr_d;
   logic [N_CH*DATA_W-1:0]   main_data_q, main_data_d;
   logic [PC_W-1:0]          main_pc_q, main_pc_d;
   logic [N_CH-1:0]          skid_we_q, skid_we_d;
   logic [N_CH*ADDR_W-1:0]   skid_addr_q, skid_addr_d;
   logic [N_CH*DATA_W-1:0]   skid_data_q, skid_data_d;
   logic [PC_W-1:0]          skid_pc_q, skid_pc_d;
   logic [CNT_W-1:0]         retire_cnt_q, retire_cnt_d;
   logic                     push, pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_EMPTY;
         main_we_q    <= '0;
         main_addr_q  <= '0;
         main_data_q  <= '0;
         main_pc_q    <= '0;
         skid_we_q    <= '0;
         skid_addr_q  <= '0;
         skid_data_q  <= '0;
         skid_pc_q    <= '0;
         retire_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         main_we_q    <= main_we_d;
         main_addr_q  <= main_addr_d;
         main_data_q  <= main_data_d;
         main_pc_q    <= main_pc_d;
         skid_we_q    <= skid_we_d;
         skid_addr_q  <= skid_addr_d;
         skid_data_q  <= skid_data_d;
         skid_pc_q    <= skid_pc_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   // A flush blocks the push but a pop in the same cycle is still committed by WB.
   assign push = in_valid & in_ready & ~flush;
   assign pop  = out_valid & out_ready;

   always_comb begin
      state_d      = state_q;
      main_we_d    = main_we_q;
      main_addr_d  = main_addr_q;
      main_data_d  = main_data_q;
      main_pc_d    = main_pc_q;
      skid_we_d    = skid_we_q;
      skid_addr_d  = skid_addr_q;
      skid_data_d  = skid_data_q;
      skid_pc_d    = skid_pc_q;
      retire_cnt_d = retire_cnt_q + {{(CNT_W-1){1'b0}}, pop};
      if (flush) begin
         state_d = S_EMPTY;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (push) begin
                  state_d     = S_ONE;
                  main_we_d   = in_we;
                  main_addr_d = in_addr;
                  main_data_d = in_data;
                  main_pc_d   = in_pc;
               end
            end
            S_ONE: begin
               if (push && pop) begin
                  main_we_d   = in_we;
                  main_addr_d = in_addr;
                  main_data_d = in_data;
                  main_pc_d   = in_pc;
               end else if (push) begin
                  state_d     = S_TWO;
                  skid_we_d   = in_we;
                  skid_addr_d = in_addr;
                  skid_data_d = in_data;
                  skid_pc_d   = in_pc;
               end else if (pop) begin
                  state_d = S_EMPTY;
               end
            end
            S_TWO: begin
               if (pop) begin
                  state_d     = S_ONE;
                  main_we_d   = skid_we_q;
                  main_addr_d = skid_addr_q;
                  main_data_d = skid_data_q;
                  main_pc_d   = skid_pc_q;
               end
            end
            default: state_d = S_EMPTY;
         endcase
      end
   end

   always_comb begin
      out_valid  = (state_q != S_EMPTY);
      occupancy  = state_q;
      out_we     = main_we_q & {N_CH{out_valid}};
      out_addr   = main_addr_q;
      out_data   = main_data_q;
      out_pc     = main_pc_q;
      retire_cnt = retire_cnt_q;
      if (SKID != 0) begin
         in_ready = ~rst & (state_q != S_TWO);
      end else begin
         in_ready = ~rst & (~out_valid | out_ready);
      end
   end

endmodule

// File: tb/tb_wb_commit_stage.sv
// tb/tb_wb_commit_stage.sv - randomized queue-model check of wb_commit_stage (SKID=1/CNT_W=4 and SKID=0/CNT_W=32)
module tb_wb_commit_stage;

   typedef struct packed {
      logic [3:0]   we;
      logic [19:0]  addr;
      logic [127:0] data;
      logic [31:0]  pc;
   } bundle_t;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, out_ready;
   logic [3:0]    in_we;
   logic [19:0]   in_addr;
   logic [127:0]  in_data;
   logic [31:0]   in_pc;

   logic          a_in_ready, a_out_valid, b_in_ready, b_out_valid;
   logic [3:0]    a_out_we, b_out_we;
   logic [19:0]   a_out_addr, b_out_addr;
   logic [127:0]  a_out_data, b_out_data;
   logic [31:0]   a_out_pc, b_out_pc;
   logic [1:0]    a_occupancy, b_occupancy;
   logic [3:0]    a_retire_cnt;
   logic [31:0]   b_retire_cnt;

   int n_vec = 0;
   int n_fail = 0;

   bundle_t     mq [2][$];
   bundle_t     mlast [2];
   int unsigned mcnt [2];

   always #5 clk = ~clk;

   wb_commit_stage #(.SKID(1), .CNT_W(4)) u_a (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_we(in_we), .in_addr(in_addr), .in_data(in_data), .in_pc(in_pc),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_we(a_out_we), .out_addr(a_out_addr),
      .out_data(a_out_data), .out_pc(a_out_pc), .occupancy(a_occupancy), .retire_cnt(a_retire_cnt)
   );

   wb_commit_stage #(.SKID(0), .CNT_W(32)) u_b (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_we(in_we), .in_addr(in_addr), .in_data(in_data), .in_pc(in_pc),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_we(b_out_we), .out_addr(b_out_addr),
      .out_data(b_out_data), .out_pc(b_out_pc), .occupancy(b_occupancy), .retire_cnt(b_retire_cnt)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bundle_t rnd_bundle(input logic [31:0] pc);
      bundle_t b;
      b.we   = 4'($urandom);
      b.addr = 20'($urandom);
      b.data = {$urandom, $urandom, $urandom, $urandom};
      b.pc   = pc;
      return b;
   endfunction

   function automatic bit exp_ready(input int k, input bit skid);
      if (rst) return 1'b0;
      if (skid) return mq[k].size() < 2;
      return (mq[k].size() == 0) || out_ready;
   endfunction

   // Queue view of the stage: capacity 2 with SKID, else 1 with pass-through acceptance on pop.
   task automatic model_step(input int k, input bit skid);
      bit rdy, pop, push;
      if (rst) begin
         mq[k].delete();
         mlast[k] = '0;
         mcnt[k]  = 0;
      end else begin
         rdy  = exp_ready(k, skid);
         pop  = (mq[k].size() > 0) && out_ready;
         push = in_valid && rdy && !flush;
         if (pop) begin
            mcnt[k]++;
            void'(mq[k].pop_front());
         end
         if (flush) mq[k].delete();
         else if (push) mq[k].push_back({in_we, in_addr, in_data, in_pc});
         if (mq[k].size() > 0) mlast[k] = mq[k][0];
      end
   endtask

   task automatic check_dut(input int k, input bit skid, input logic ir, input logic ov,
                            input logic [3:0] we, input logic [19:0] ad, input logic [127:0] da,
                            input logic [31:0] pc, input logic [1:0] occ, input logic [31:0] cnt,
                            input logic [31:0] cmask);
      bundle_t h;
      h = (mq[k].size() > 0) ? mq[k][0] : mlast[k];
      chk($sformatf("d%0d_in_ready", k), 128'(ir), 128'(exp_ready(k, skid)));
      chk($sformatf("d%0d_out_valid", k), 128'(ov), 128'(mq[k].size() > 0));
      chk($sformatf("d%0d_out_we", k), 128'(we), (mq[k].size() > 0) ? 128'(h.we) : 128'(0));
      chk($sformatf("d%0d_out_addr", k), 128'(ad), 128'(h.addr));
      chk($sformatf("d%0d_out_data", k), da, h.data);
      chk($sformatf("d%0d_out_pc", k), 128'(pc), 128'(h.pc));
      chk($sformatf("d%0d_occupancy", k), 128'(occ), 128'(mq[k].size()));
      chk($sformatf("d%0d_retire_cnt", k), 128'(cnt), 128'(mcnt[k] & cmask));
   endtask

   // Called at a negedge: apply inputs, compare both DUTs, then advance the model on the posedge.
   task automatic step(input logic r, input logic f, input logic iv, input logic ordy, input bundle_t b);
      rst = r; flush = f; in_valid = iv; out_ready = ordy;
      in_we = b.we; in_addr = b.addr; in_data = b.data; in_pc = b.pc;
      #1;
      check_dut(0, 1'b1, a_in_ready, a_out_valid, a_out_we, a_out_addr, a_out_data, a_out_pc,
                a_occupancy, {28'd0, a_retire_cnt}, 32'h0000_000F);
      check_dut(1, 1'b0, b_in_ready, b_out_valid, b_out_we, b_out_addr, b_out_data, b_out_pc,
                b_occupancy, b_retire_cnt, 32'hFFFF_FFFF);
      @(posedge clk);
      model_step(0, 1'b1);
      model_step(1, 1'b0);
      @(negedge clk);
   endtask

   initial begin
      bundle_t z, b1;
      z = '0;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_we = '0; in_addr = '0; in_data = '0; in_pc = '0;
      for (int k = 0; k < 2; k++) begin
         mlast[k] = '0;
         mcnt[k]  = 0;
      end
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      step(1, 0, 0, 1, z);

      b1 = '0;
      b1.we = 4'b0001; b1.addr = 20'd3; b1.data = 128'h1234; b1.pc = 32'hBFC0_0000;
      step(0, 0, 1, 1, b1);
      chk("t1_out_valid", 128'(a_out_valid), 128'(1));
      chk("t1_out_we", 128'(a_out_we), 128'(4'b0001));
      chk("t1_out_pc", 128'(a_out_pc), 128'(32'hBFC0_0000));
      step(0, 0, 0, 1, z);
      chk("t1_retire_cnt", 128'(a_retire_cnt), 128'(1));

      step(0, 0, 1, 0, rnd_bundle(32'hA));
      step(0, 0, 1, 0, rnd_bundle(32'hB));
      out_ready = 1'b0; in_valid = 1'b1; #1;
      chk("t2_occupancy", 128'(a_occupancy), 128'(2));
      chk("t2_in_ready", 128'(a_in_ready), 128'(0));
      chk("t2_head_a", 128'(a_out_pc), 128'(32'hA));
      step(0, 0, 1, 0, rnd_bundle(32'hC));
      step(0, 0, 1, 1, rnd_bundle(32'hC));
      chk("t2_head_b", 128'(a_out_pc), 128'(32'hB));
      step(0, 0, 1, 1, rnd_bundle(32'hC));
      chk("t2_head_c", 128'(a_out_pc), 128'(32'hC));
      step(0, 0, 0, 1, z);
      chk("t2_retire_cnt", 128'(a_retire_cnt), 128'(4));

      step(0, 0, 1, 0, rnd_bundle(32'hD));
      step(0, 0, 1, 0, rnd_bundle(32'hE));
      step(0, 1, 1, 0, rnd_bundle(32'hF));
      chk("t3_out_valid", 128'(a_out_valid), 128'(0));
      chk("t3_out_we", 128'(a_out_we), 128'(0));
      chk("t3_occupancy", 128'(a_occupancy), 128'(0));

      step(0, 0, 1, 1, rnd_bundle(32'h40));
      step(0, 0, 1, 0, rnd_bundle(32'h41));
      step(0, 0, 1, 1, rnd_bundle(32'h42));
      step(0, 0, 0, 1, z);

      step(0, 0, 1, 0, rnd_bundle(32'h50));
      step(0, 0, 1, 0, rnd_bundle(32'h51));
      step(1, 0, 0, 0, z);
      chk("t5_out_valid", 128'(a_out_valid), 128'(0));
      chk("t5_in_ready_rst", 128'(a_in_ready), 128'(0));
      chk("t5_retire_cnt", 128'(a_retire_cnt), 128'(0));
      step(0, 0, 0, 0, z);
      chk("t5_in_ready_rel", 128'(a_in_ready), 128'(1));

      for (int i = 0; i < 17; i++) step(0, 0, 1, 1, rnd_bundle(32'h100 + 32'(i)));
      step(0, 0, 0, 1, z);
      chk("t6_retire_wrap", 128'(a_retire_cnt), 128'(1));

      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 3) != 0), 1'($urandom), rnd_bundle($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
